// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter in front of a 4-bank x 16-entry x 8-bit single-port scratch memory.
// After reset it zero-fills all 64 locations, then grants one requester per cycle and
// routes the registered memory read data back to the requester that issued the read.
module mem_bank_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 3,
  parameter int unsigned CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [2*NREQ-1:0]    req_bank,
  input  logic [4*NREQ-1:0]    req_addr,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 init_done,
  output logic [CNTW*NREQ-1:0] gnt_count,
  output logic [1:0]           mem_bank,
  output logic [3:0]           mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  input  logic [7:0]           mem_rdata
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so the wrap-around sum rr_ptr + k cannot overflow before the modulo.
  localparam int unsigned IdxW = PtrW + 1;

  typedef enum logic [0:0] {
    StInit,
    StServe
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      ptr_q, ptr_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] cnt_q [NREQ];
  logic [CNTW-1:0] cnt_d [NREQ];

  logic            found;
  logic [PtrW-1:0] winner;
  logic [IdxW-1:0] idx;
  logic            grant;

  // Round-robin search: first valid requester at or above rr_q, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_q} + IdxW'(k);
      if (idx >= IdxW'(NREQ)) begin
        idx = idx - IdxW'(NREQ);
      end
      if (!found && req_valid[idx[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PtrW-1:0];
      end
    end
  end

  // A grant is only issued while serving; a cycle with rst high never hands out an accept,
  // since its handshake would be discarded by the reset edge.
  assign grant = found && (state_q == StServe) && !rst;

  // One-hot accept to the winner, or all zero.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Sweep / serve FSM next state and memory drive.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    init_done = 1'b0;
    mem_we    = 1'b0;
    mem_bank  = 2'd0;
    mem_addr  = 4'd0;
    mem_wdata = 8'd0;
    unique case (state_q)
      StInit: begin
        mem_we   = 1'b1;
        mem_bank = ptr_q[5:4];
        mem_addr = ptr_q[3:0];
        ptr_d    = ptr_q + 6'd1;
        if (ptr_q == 6'd63) begin
          state_d = StServe;
        end
      end
      StServe: begin
        init_done = 1'b1;
        if (grant) begin
          mem_we    = req_we[winner];
          mem_bank  = req_bank[{winner, 1'b0} +: 2];
          mem_addr  = req_addr[{winner, 2'b00} +: 4];
          mem_wdata = req_wdata[{winner, 3'b000} +: 8];
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Pointer advance, response tagging and saturating grant counters on each handshake.
  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (grant) begin
      rr_d = (winner == PtrW'(NREQ - 1)) ? '0 : winner + PtrW'(1);
      if (!req_we[winner]) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = IDW'(winner);
      end
      if (cnt_q[winner] != '1) begin
        cnt_d[winner] = cnt_q[winner] + CNTW'(1);
      end
    end
  end

  // State registers with synchronous reset; a pending read response is dropped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      ptr_q       <= 6'd0;
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack the per-requester counters onto the flat output bus.
  always_comb begin
    gnt_count = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_count[i*CNTW +: CNTW] = cnt_q[i];
    end
  end

  // Memory output is already registered, so read data passes straight through; it is
  // forced to zero outside a response so idle reads never leak onto rsp_data.
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_valid_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Scoreboard bench for mem_bank_arbiter: stimulus pushes expected read responses,
// a forked monitor pops and compares them whenever rsp_valid is seen.
module tb_mem_bank_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 3;
  localparam int unsigned CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [2*NREQ-1:0]    req_bank;
  logic [4*NREQ-1:0]    req_addr;
  logic [8*NREQ-1:0]    req_wdata;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [7:0]           rsp_data;
  logic                 init_done;
  logic [CNTW*NREQ-1:0] gnt_count;
  logic [1:0]           mem_bank;
  logic [3:0]           mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_we;
  logic [7:0]           mem_rdata;

  mem_bank_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW),
    .CNTW(CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_bank (req_bank),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .init_done(init_done),
    .gnt_count(gnt_count),
    .mem_bank (mem_bank),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: single port, registered read, seeded with junk so the sweep is visible.
  logic [7:0] mem [64];
  bit         seeded;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hEE;
      seeded <= 1'b1;
    end else begin
      if (mem_we) mem[{mem_bank, mem_addr}] <= mem_wdata;
      mem_rdata <= mem[{mem_bank, mem_addr}];
    end
  end

  int cyc_n;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     data;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Drive one cycle of requests at negedge, check the accept and memory drive, and queue
  // the expected response when a read is granted.
  task automatic cycle_drive(input logic [1:0] v, input logic [1:0] we, input logic [3:0] bank,
                             input logic [7:0] addr, input logic [15:0] wd,
                             input logic [1:0] exp_rdy, input logic [7:0] exp_rd);
    int w;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_bank  = bank;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      w = exp_rdy[1] ? 1 : 0;
      chk("mem_we", 32'(mem_we), 32'(we[w]));
      chk("mem_bank", 32'(mem_bank), 32'(bank[2*w +: 2]));
      chk("mem_addr", 32'(mem_addr), 32'(addr[4*w +: 4]));
      if (we[w]) chk("mem_wdata", 32'(mem_wdata), 32'(wd[8*w +: 8]));
      else sb.push_back('{id: IDW'(w), data: exp_rd, due: cyc_n + 1});
    end else begin
      chk("idle_mem", 32'({mem_we, mem_bank, mem_addr, mem_wdata}), 32'd0);
    end
  endtask

  task automatic idle();
    cycle_drive(2'b00, 2'b00, 4'h0, 8'h00, 16'h0000, 2'b00, 8'h00);
  endtask

  // Assert rst for one edge from the current point, check reset values, then release.
  task automatic rst_pulse();
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_gnt_count", 32'(gnt_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
  endtask

  // Follow n sweep steps from location 0; caller is just after a negedge.
  task automatic sweep_check(input int n);
    logic [5:0] kk;
    for (int k = 0; k < n; k++) begin
      kk = 6'(k);
      chk("sweep_drive", 32'({mem_we, mem_bank, mem_addr, mem_wdata}), 32'({1'b1, kk, 8'h00}));
      chk("sweep_init_done", 32'(init_done), 32'd0);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (sb.size() > 0 && sb[0].due < cyc_n) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: no rsp_valid for id %0d, required at cycle %0d",
                     sb[0].id, sb[0].due);
            void'(sb.pop_front());
          end
          if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rsp_unexpected: rsp_valid with id %0d data %0h, none required",
                       rsp_id, rsp_data);
            end else begin
              e = sb.pop_front();
              chk("rsp_cycle", 32'(cyc_n), 32'(e.due));
              chk("rsp_id", 32'(rsp_id), 32'(e.id));
              chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
          end
        end
      end
    join_none

    // Sweep after reset: 64 cycles, then init_done; location 63 reads back zero.
    rst_pulse();
    sweep_check(64);
    chk("init_done_rise", 32'(init_done), 32'd1);
    repeat (6) idle();
    cycle_drive(2'b01, 2'b00, 4'b00_11, 8'h0F, 16'h0000, 2'b01, 8'h00);

    // Write then read back the same location; rr_ptr is 1 but only requester 0 is valid.
    cycle_drive(2'b01, 2'b01, 4'b00_10, 8'h07, 16'h00A5, 2'b01, 8'h00);
    cycle_drive(2'b01, 2'b00, 4'b00_10, 8'h07, 16'h0000, 2'b01, 8'hA5);
    idle();
    chk("gnt_count_ab", 32'(gnt_count), 32'h03);

    // Fresh start: each requester writes its own location, then 8 contended reads.
    idle();
    rst_pulse();
    sweep_check(64);
    cycle_drive(2'b01, 2'b01, 4'b01_00, 8'h21, 16'h2211, 2'b01, 8'h00);
    cycle_drive(2'b10, 2'b10, 4'b01_00, 8'h21, 16'h2211, 2'b10, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle_drive(2'b11, 2'b00, 4'b01_00, 8'h21, 16'h0000, 2'b01, 8'h11);
      else cycle_drive(2'b11, 2'b00, 4'b01_00, 8'h21, 16'h0000, 2'b10, 8'h22);
    end
    idle();
    // one write plus four reads each
    chk("gnt_count_alt", 32'(gnt_count), 32'h55);

    // Requester 1 alone three times (rr_ptr returns to 0 each time), then both: 0 then 1.
    repeat (3) cycle_drive(2'b10, 2'b00, 4'b01_00, 8'h21, 16'h0000, 2'b10, 8'h22);
    cycle_drive(2'b11, 2'b00, 4'b01_00, 8'h21, 16'h0000, 2'b01, 8'h11);
    cycle_drive(2'b11, 2'b00, 4'b01_00, 8'h21, 16'h0000, 2'b10, 8'h22);
    idle();
    chk("gnt_count_rr", 32'(gnt_count), 32'h96);

    // Reset mid-sweep at location 30: the sweep restarts from 0.
    idle();
    rst_pulse();
    sweep_check(30);
    chk("sweep_at_30", 32'({mem_we, mem_bank, mem_addr}), 32'({1'b1, 6'd30}));
    rst_pulse();
    sweep_check(64);
    chk("init_done_resweep", 32'(init_done), 32'd1);

    // Reset one cycle after a read grant: that response still shows, nothing follows reset.
    cycle_drive(2'b01, 2'b00, 4'b00_00, 8'h01, 16'h0000, 2'b01, 8'h00);
    @(negedge clk);
    rst_pulse();
    sweep_check(64);
    chk("init_done_after_read_rst", 32'(init_done), 32'd1);

    // Counter saturation at 4'hF.
    repeat (14) cycle_drive(2'b01, 2'b01, 4'b00_00, 8'h03, 16'h0042, 2'b01, 8'h00);
    idle();
    chk("gnt_count_14", 32'(gnt_count), 32'h0E);
    cycle_drive(2'b01, 2'b01, 4'b00_00, 8'h03, 16'h0042, 2'b01, 8'h00);
    idle();
    chk("gnt_count_15", 32'(gnt_count), 32'h0F);
    repeat (3) cycle_drive(2'b01, 2'b01, 4'b00_00, 8'h03, 16'h0042, 2'b01, 8'h00);
    idle();
    chk("gnt_count_sat", 32'(gnt_count), 32'h0F);

    repeat (3) idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
